// File: rtl/spi_peripheral.sv
// SPI peripheral endpoint, CPOL=1 / CPHA=0, MSB first, oversampled in the clk domain.
// Optional frame_err output is built when SPI_PERIPHERAL_FRAME_ERR_EN is defined.
module spi_peripheral #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SPI_CLK,
    input  logic                  SPI_MOSI,
    input  logic                  SPI_EN,
    output logic                  SPI_MISO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
    ,
    output logic                  frame_err
`endif
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam int              SETTLE   = SYNC_STAGES + 1;
    localparam int              SET_W    = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH);
    localparam logic [SET_W-1:0] SET_END  = SET_W'(SETTLE);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, en_sync;
    logic                   sclk_s, mosi_s, en_s;
    logic                   sclk_p1, en_p1;
    logic                   sclk_fall, sclk_rise, en_rise, en_fall, en_start;
    logic [SET_W-1:0]       settle_cnt;
    logic                   armed;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   in_shift, word_done, load_tx, do_fall, do_rise, miso_nxt;

    logic                   hold_full;
    logic [DATA_WIDTH-1:0]  hold_data;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  tx_shift, rx_shift;

    // Stage 0: synchronisers plus one edge-detect register on clock and select
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '1;
            mosi_sync <= '0;
            en_sync   <= '0;
            sclk_p1   <= 1'b1;
            en_p1     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            en_sync   <= {en_sync[SYNC_STAGES-2:0], SPI_EN};
            sclk_p1   <= sclk_s;
            en_p1     <= en_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign en_s      = en_sync[SYNC_STAGES-1];
    assign sclk_fall = sclk_p1 & ~sclk_s;
    assign sclk_rise = ~sclk_p1 & sclk_s;
    assign en_rise   = en_s & ~en_p1;
    assign en_fall   = ~en_s & en_p1;
    assign en_start  = en_rise & armed;

    // A select already high when reset releases must be dropped before a new frame may start
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else if (settle_cnt != SET_END) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else if (!en_s) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en_start) state_nxt = SHIFT;
            SHIFT:   if (en_fall)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Word completion is honoured even after the select has dropped in the same cycle
    always_comb begin
        in_shift  = (state == SHIFT);
        word_done = (bit_cnt == LAST_CNT);
        load_tx   = ((state == IDLE) && en_start) || (in_shift && word_done);
        do_fall   = in_shift && sclk_fall;
        do_rise   = in_shift && sclk_rise && (bit_cnt != '0);
        miso_nxt  = in_shift ? tx_shift[DATA_WIDTH-1] : 1'b0;
    end

    assign accept   = tx_valid && !hold_full;
    assign tx_ready = !hold_full;

    // Stage 1: holding register, shifters, bit counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            SPI_MISO  <= 1'b0;
        end else begin
            if (load_tx && hold_full) hold_full <= 1'b0;
            else if (accept)          hold_full <= 1'b1;

            if ((state == IDLE) && en_start) bit_cnt <= '0;
            else if (word_done)              bit_cnt <= '0;
            else if (do_fall)                bit_cnt <= bit_cnt + 1'b1;

            rx_valid <= word_done;
            if (word_done) rx_data <= rx_shift;
            SPI_MISO <= miso_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) hold_data <= tx_data;
        if (do_fall) rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
        if (load_tx)      tx_shift <= hold_full ? hold_data : DEFAULT_TX;
        else if (do_rise) tx_shift <= tx_shift << 1;
    end

`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
    logic             words_seen;
    logic [CNT_W-1:0] cnt_after;
    logic             abort;

    always_comb begin
        cnt_after = do_fall ? bit_cnt + 1'b1 : bit_cnt;
        abort     = in_shift && en_fall &&
                    (((cnt_after != '0) && (cnt_after != LAST_CNT)) ||
                     ((cnt_after == '0) && !words_seen));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            words_seen <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= abort;
            if ((state == IDLE) && en_start) words_seen <= 1'b0;
            else if (in_shift && word_done)  words_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: a behavioural SPI master plus a queue model of the
// tx holding register and the expected rx words.
module tb_spi_peripheral;

    logic       clk = 1'b0;
    logic       rst;
    logic       SPI_CLK, SPI_MOSI, SPI_EN, SPI_MISO;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
    logic       frame_err;
`endif

    spi_peripheral #(.DATA_WIDTH(8), .SYNC_STAGES(2), .DEFAULT_TX(8'h00)) dut (
        .clk(clk), .rst(rst),
        .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_EN(SPI_EN), .SPI_MISO(SPI_MISO),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid)
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
        , .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_bad = 0;
    int         ferr_cnt = 0;
    logic [7:0] rx_got[$];
    logic       m_full = 1'b0;
    logic [7:0] m_val = 8'h00;
    logic [7:0] last_rx = 8'h00;
    logic [7:0] m_mosi[0:3];

    always @(negedge clk) begin
        if (rx_valid) rx_got.push_back(rx_data);
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
        if (frame_err) ferr_cnt++;
`endif
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] model_pop();
        if (m_full) begin
            m_full = 1'b0;
            return m_val;
        end
        return 8'h00;
    endfunction

    task automatic tx_push(input logic [7:0] v);
        @(negedge clk);
        tx_data  = v;
        tx_valid = 1'b1;
        if (!m_full) begin
            m_full = 1'b1;
            m_val  = v;
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Master side: drive MOSI while SPI_CLK high, sample MISO at the falling edge
    task automatic send_word(input logic [7:0] mo, input int push_at, input logic [7:0] push_v,
                             input int nbits, output logic [7:0] miso_w);
        miso_w = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            SPI_MOSI = mo[7-i];
            wait_n(4);
            SPI_CLK = 1'b0;
            miso_w[7-i] = SPI_MISO;
            if (i == push_at) begin
                tx_push(push_v);
                wait_n(6);
            end else begin
                wait_n(8);
            end
            SPI_CLK = 1'b1;
            wait_n(4);
        end
    endtask

    task automatic frame(input int nw, input int push_word, input logic [7:0] push_v, input int abort_bits);
        logic [7:0] cur, mw;
        logic [7:0] exp_rx[$];
        rx_got.delete();
        ferr_cnt = 0;
        SPI_EN = 1'b1;
        wait_n(10);
        cur = model_pop();
        check_eq("tx_ready_start", tx_ready, !m_full);
        for (int w = 0; w < nw; w++) begin
            if (w == nw - 1 && abort_bits > 0) begin
                send_word(m_mosi[w], (w == push_word) ? 1 : -1, push_v, abort_bits, mw);
            end else begin
                send_word(m_mosi[w], (w == push_word) ? 4 : -1, push_v, 8, mw);
                check_eq("miso_word", mw, cur);
                exp_rx.push_back(m_mosi[w]);
                last_rx = m_mosi[w];
                cur = model_pop();
                check_eq("tx_ready_word", tx_ready, !m_full);
            end
        end
        wait_n(4);
        SPI_EN = 1'b0;
        SPI_MOSI = 1'b0;
        wait_n(12);
        check_eq("rx_count", rx_got.size(), exp_rx.size());
        for (int i = 0; i < exp_rx.size() && i < rx_got.size(); i++)
            check_eq("rx_word", rx_got[i], exp_rx[i]);
        check_eq("rx_data_hold", rx_data, last_rx);
        check_eq("miso_idle", SPI_MISO, 1'b0);
        check_eq("tx_ready_end", tx_ready, !m_full);
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
        check_eq("frame_err_cnt", ferr_cnt, (abort_bits > 0) ? 1 : 0);
`endif
    endtask

    initial begin
        logic [7:0] mw;
        int         nw, pw;
        rst = 1'b1; SPI_CLK = 1'b1; SPI_MOSI = 1'b0; SPI_EN = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;
        wait_n(3);
        check_eq("rst_miso", SPI_MISO, 1'b0);
        check_eq("rst_tx_ready", tx_ready, 1'b1);
        check_eq("rst_rx_valid", rx_valid, 1'b0);
        check_eq("rst_rx_data", rx_data, 8'h00);
        rst = 1'b0;
        wait_n(10);

        // preloaded A5, master sends 3C
        tx_push(8'hA5);
        m_mosi[0] = 8'h3C;
        frame(1, -1, 8'h00, 0);

        // nothing queued, default word goes out
        m_mosi[0] = 8'hFF;
        frame(1, -1, 8'h00, 0);

        // three-word frame with a write during word 0
        tx_push(8'h11);
        m_mosi[0] = 8'h01; m_mosi[1] = 8'h80; m_mosi[2] = 8'h7E;
        frame(3, 0, 8'h22, 0);

        // aborted word after 5 falls, then a clean frame
        m_mosi[0] = 8'h9D;
        frame(1, -1, 8'h00, 5);
        m_mosi[0] = 8'hC3;
        frame(1, -1, 8'h00, 0);

        // reset in the middle of a word, select held high across it
        SPI_EN = 1'b1;
        wait_n(10);
        mw = model_pop();
        send_word(8'hB6, 1, 8'h99, 4, mw);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_miso", SPI_MISO, 1'b0);
        check_eq("mid_rst_tx_ready", tx_ready, 1'b1);
        check_eq("mid_rst_rx_valid", rx_valid, 1'b0);
        check_eq("mid_rst_rx_data", rx_data, 8'h00);
        rst = 1'b0;
        m_full = 1'b0;
        last_rx = 8'h00;
        rx_got.delete();
        for (int i = 0; i < 8; i++) begin
            SPI_CLK = 1'b0; wait_n(8);
            SPI_CLK = 1'b1; wait_n(8);
        end
        check_eq("post_rst_rx_count", rx_got.size(), 0);
        check_eq("post_rst_miso", SPI_MISO, 1'b0);
        SPI_EN = 1'b0;
        wait_n(12);
        m_mosi[0] = 8'h5C;
        frame(1, -1, 8'h00, 0);

        // clock activity without select, holding kept; a second write is ignored
        tx_push(8'h5A);
        tx_push(8'h77);
        rx_got.delete();
        for (int i = 0; i < 8; i++) begin
            SPI_MOSI = i[0];
            SPI_CLK = 1'b0; wait_n(8);
            SPI_CLK = 1'b1; wait_n(8);
        end
        check_eq("idle_rx_count", rx_got.size(), 0);
        check_eq("idle_miso", SPI_MISO, 1'b0);
        check_eq("idle_tx_ready", tx_ready, 1'b0);
        SPI_MOSI = 1'b0;
        m_mosi[0] = 8'h96;
        frame(1, -1, 8'h00, 0);

        // randomized frames
        for (int r = 0; r < 20; r++) begin
            nw = $urandom_range(1, 3);
            for (int w = 0; w < 4; w++) m_mosi[w] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) tx_push(8'($urandom));
            if ($urandom_range(0, 3) == 0) tx_push(8'($urandom));
            pw = $urandom_range(0, nw);
            frame(nw, (pw == nw) ? -1 : pw, 8'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
